// File: rtl/hub75_pkg.sv
// Shared constants and FSM encoding for the HUB75 panel scan driver.
package hub75_pkg;

    localparam int COLS_DEF      = 64;
    localparam int ROWS_HALF_DEF = 16;
    localparam int ON_CYCLES_DEF = 64;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_PREFETCH = 3'd1;
    localparam state_t S_SHIFT    = 3'd2;
    localparam state_t S_BLANK    = 3'd3;
    localparam state_t S_LATCH    = 3'd4;
    localparam state_t S_DISPLAY  = 3'd5;

endpackage

// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan driver: sweeps col/row into matrix_generate, shifts pixels
// out, latches and displays each row, and pulses frame_tick per frame.
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int ROWS_HALF = ROWS_HALF_DEF,
    parameter int ON_CYCLES = ON_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic [$clog2(COLS)-1:0]      col,
    output logic [$clog2(ROWS_HALF)-1:0] row,
    input  logic                         R0,
    input  logic                         G0,
    input  logic                         B0,
    input  logic                         R1,
    input  logic                         G1,
    input  logic                         B1,
    output logic                         p_r0,
    output logic                         p_g0,
    output logic                         p_b0,
    output logic                         p_r1,
    output logic                         p_g1,
    output logic                         p_b1,
    output logic                         p_clk,
    output logic                         p_lat,
    output logic                         p_oe_n,
    output logic [$clog2(ROWS_HALF)-1:0] p_addr,
    output logic                         frame_tick
);

    localparam int CW = $clog2(COLS);
    localparam int AW = $clog2(ROWS_HALF);
    localparam int OW = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(ROWS_HALF - 1);
    localparam logic [OW-1:0] ON_LAST  = OW'(ON_CYCLES - 1);

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] on_q, on_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] row_q, row_d;
    logic [5:0]    pix_q, pix_d;
    logic          clk_q, clk_d;
    logic          lat_q, lat_d;
    logic          oe_n_q, oe_n_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          tick_q, tick_d;

    logic [5:0]    pix_in;

    assign pix_in = {R0, G0, B0, R1, G1, B1};

    // Outputs are computed for the state being entered, so every pin is a flop.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        on_d    = on_q;
        col_d   = col_q;
        row_d   = row_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        clk_d   = 1'b0;
        lat_d   = 1'b0;
        oe_n_d  = 1'b1;
        tick_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_PREFETCH;
                    col_d   = '0;
                end
            end
            S_PREFETCH: begin
                state_d = S_SHIFT;
                phase_d = 1'b0;
                cnt_d   = '0;
                pix_d   = pix_in;
                col_d   = col_q + CW'(1);
            end
            S_SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    clk_d   = 1'b1;
                end else if (cnt_q == COL_LAST) begin
                    state_d = S_BLANK;
                    addr_d  = row_q;
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = cnt_q + CW'(1);
                    pix_d   = pix_in;
                    col_d   = col_q + CW'(1);
                end
            end
            S_BLANK: begin
                state_d = S_LATCH;
                lat_d   = 1'b1;
            end
            S_LATCH: begin
                state_d = S_DISPLAY;
                on_d    = '0;
                oe_n_d  = 1'b0;
            end
            S_DISPLAY: begin
                if (on_q == ON_LAST) begin
                    state_d = enable ? S_PREFETCH : S_IDLE;
                    col_d   = '0;
                    tick_d  = (row_q == ROW_LAST);
                    row_d   = (row_q == ROW_LAST) ? '0 : row_q + AW'(1);
                end else begin
                    on_d   = on_q + OW'(1);
                    oe_n_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            on_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
            clk_q   <= 1'b0;
            lat_q   <= 1'b0;
            oe_n_q  <= 1'b1;
            addr_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
            clk_q   <= clk_d;
            lat_q   <= lat_d;
            oe_n_q  <= oe_n_d;
            addr_q  <= addr_d;
            tick_q  <= tick_d;
        end
    end

    assign col        = col_q;
    assign row        = row_q;
    assign p_r0       = pix_q[5];
    assign p_g0       = pix_q[4];
    assign p_b0       = pix_q[3];
    assign p_r1       = pix_q[2];
    assign p_g1       = pix_q[1];
    assign p_b1       = pix_q[0];
    assign p_clk      = clk_q;
    assign p_lat      = lat_q;
    assign p_oe_n     = oe_n_q;
    assign p_addr     = addr_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver: first-row vector table, frame timing,
// enable drop, mid-display reset, and a small COLS=8/ON_CYCLES=1 instance.
module tb_hub75_scan_driver;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic [5:0] col;
    logic [3:0] row, p_addr;
    logic       R0, G0, B0, R1, G1, B1;
    logic       p_r0, p_g0, p_b0, p_r1, p_g1, p_b1;
    logic       p_clk, p_lat, p_oe_n, frame_tick;

    logic       rst2, en2;
    logic [2:0] col2;
    logic [3:0] row2, p_addr2;
    logic       q_r0, q_g0, q_b0, q_r1, q_g1, q_b1;
    logic       p_clk2, p_lat2, p_oe_n2, frame_tick2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    logic [3:0] addr_log[$];

    always #5 clk = ~clk;

    assign R0 = col[0];
    assign G0 = col[1];
    assign B0 = row[0];
    assign R1 = ~col[0];
    assign G1 = row[1];
    assign B1 = 1'b1;

    hub75_scan_driver dut (
        .clk(clk), .rst(rst), .enable(enable),
        .col(col), .row(row),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .p_r0(p_r0), .p_g0(p_g0), .p_b0(p_b0),
        .p_r1(p_r1), .p_g1(p_g1), .p_b1(p_b1),
        .p_clk(p_clk), .p_lat(p_lat), .p_oe_n(p_oe_n),
        .p_addr(p_addr), .frame_tick(frame_tick)
    );

    hub75_scan_driver #(.COLS(8), .ROWS_HALF(16), .ON_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst2), .enable(en2),
        .col(col2), .row(row2),
        .R0(col2[0]), .G0(1'b0), .B0(1'b0),
        .R1(1'b0), .G1(1'b0), .B1(1'b0),
        .p_r0(q_r0), .p_g0(q_g0), .p_b0(q_b0),
        .p_r1(q_r1), .p_g1(q_g1), .p_b1(q_b1),
        .p_clk(p_clk2), .p_lat(p_lat2), .p_oe_n(p_oe_n2),
        .p_addr(p_addr2), .frame_tick(frame_tick2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " col"}, 32'(col), 32'd0);
        chk({tag, " row"}, 32'(row), 32'd0);
        chk({tag, " data"},
            32'({p_r0, p_g0, p_b0, p_r1, p_g1, p_b1}), 32'd0);
        chk({tag, " p_clk"}, 32'(p_clk), 32'd0);
        chk({tag, " p_lat"}, 32'(p_lat), 32'd0);
        chk({tag, " p_oe_n"}, 32'(p_oe_n), 32'd1);
        chk({tag, " p_addr"}, 32'(p_addr), 32'd0);
        chk({tag, " frame_tick"}, 32'(frame_tick), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Continuous panel-protocol monitor on the default instance.
    initial begin : mon
        int   edge_k;
        int   run;
        logic prev_clk;
        edge_k   = 0;
        run      = 0;
        prev_clk = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                edge_k = 0;
                run    = 0;
            end else begin
                if (p_clk && !prev_clk) begin
                    chk("edge r0", 32'(p_r0), 32'(edge_k % 2));
                    chk("edge r1", 32'(p_r1), 32'(1 - edge_k % 2));
                    edge_k++;
                end
                if (p_lat) begin
                    chk("edges per row", 32'(edge_k), 32'd64);
                    edge_k = 0;
                    addr_log.push_back(p_addr);
                end
                if (!p_oe_n) begin
                    chk("oe overlap", 32'({p_clk, p_lat}), 32'd0);
                    run++;
                end else if (run > 0) begin
                    chk("oe low run", 32'(run), 32'd64);
                    run = 0;
                end
            end
            prev_clk = p_clk;
        end
    end

    typedef struct {
        int         t;
        logic [5:0] col;
        logic [3:0] row;
        logic       pclk;
        logic       lat;
        logic       oe_n;
        logic       r0;
        logic       r1;
        logic       b0;
        logic [3:0] addr;
        logic       tick;
    } vec_t;

    vec_t tab[14];

    initial begin
        int k;
        int tk;
        int rises;
        int lows;
        logic prev;
        logic [31:0] act, exp;

        tab[0]  = '{0,   6'd0,  4'd0, 0, 0, 1, 0, 0, 0, 4'd0, 0};
        tab[1]  = '{1,   6'd1,  4'd0, 0, 0, 1, 0, 1, 0, 4'd0, 0};
        tab[2]  = '{2,   6'd1,  4'd0, 1, 0, 1, 0, 1, 0, 4'd0, 0};
        tab[3]  = '{3,   6'd2,  4'd0, 0, 0, 1, 1, 0, 0, 4'd0, 0};
        tab[4]  = '{4,   6'd2,  4'd0, 1, 0, 1, 1, 0, 0, 4'd0, 0};
        tab[5]  = '{21,  6'd11, 4'd0, 0, 0, 1, 0, 1, 0, 4'd0, 0};
        tab[6]  = '{127, 6'd0,  4'd0, 0, 0, 1, 1, 0, 0, 4'd0, 0};
        tab[7]  = '{128, 6'd0,  4'd0, 1, 0, 1, 1, 0, 0, 4'd0, 0};
        tab[8]  = '{129, 6'd0,  4'd0, 0, 0, 1, 1, 0, 0, 4'd0, 0};
        tab[9]  = '{130, 6'd0,  4'd0, 0, 1, 1, 1, 0, 0, 4'd0, 0};
        tab[10] = '{131, 6'd0,  4'd0, 0, 0, 0, 1, 0, 0, 4'd0, 0};
        tab[11] = '{194, 6'd0,  4'd0, 0, 0, 0, 1, 0, 0, 4'd0, 0};
        tab[12] = '{195, 6'd0,  4'd1, 0, 0, 1, 1, 0, 0, 4'd0, 0};
        tab[13] = '{196, 6'd1,  4'd1, 0, 0, 1, 0, 1, 1, 4'd0, 0};

        rst    = 1'b1;
        rst2   = 1'b1;
        enable = 1'b0;
        en2    = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst  = 1'b0;
        rst2 = 1'b0;
        en2  = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle oe_n", 32'(p_oe_n), 32'd1);

        enable = 1'b1;
        t0     = cyc + 1;
        foreach (tab[i]) begin
            while (cyc - t0 < tab[i].t) @(negedge clk);
            act = 32'({col, row, p_clk, p_lat, p_oe_n, p_r0, p_r1, p_b0,
                       p_addr, frame_tick});
            exp = 32'({tab[i].col, tab[i].row, tab[i].pclk, tab[i].lat,
                       tab[i].oe_n, tab[i].r0, tab[i].r1, tab[i].b0,
                       tab[i].addr, tab[i].tick});
            chk($sformatf("vec t=%0d", tab[i].t), act, exp);
        end

        k = 0;
        while (!frame_tick && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("first tick time", 32'(cyc - t0), 32'd3120);
        tk = cyc;
        @(negedge clk);
        chk("tick width", 32'(frame_tick), 32'd0);
        k = 0;
        while (!frame_tick && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("tick spacing", 32'(cyc - tk), 32'd3120);
        chk("addr log size", 32'(addr_log.size() >= 17), 32'd1);
        for (int i = 0; i < 17 && i < addr_log.size(); i++)
            chk($sformatf("addr seq %0d", i), 32'(addr_log[i]),
                32'(i % 16));

        while (cyc - t0 < 6240 + 3 * 195 + 21) @(negedge clk);
        chk("drop at shift", 32'({col, p_clk}), 32'({6'd11, 1'b0}));
        enable = 1'b0;
        k = 0;
        while (!p_lat && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drop latch addr", 32'({p_lat, p_addr}), 32'({1'b1, 4'd3}));
        repeat (80) @(negedge clk);
        rises = 0;
        lows  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rises += int'(p_clk);
            lows  += int'(!p_oe_n);
        end
        chk("idle quiet", 32'({rises[15:0], lows[15:0]}), 32'd0);
        enable = 1'b1;
        k = 0;
        while (!p_lat && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("resume addr", 32'({p_lat, p_addr}), 32'({1'b1, 4'd4}));

        k = 0;
        while (!(p_lat && p_addr == 4'd7) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reach row 7", 32'(p_lat), 32'd1);
        repeat (10) @(negedge clk);
        chk("in display", 32'(p_oe_n), 32'd0);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk_reset("mid rst");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post rst idle", 32'({p_oe_n, p_lat}), 32'd2);
        enable = 1'b1;
        k = 0;
        while (!p_lat && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("restart addr", 32'({p_lat, p_addr}), 32'({1'b1, 4'd0}));

        k = 0;
        while (!p_lat2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("small latch seen", 32'(p_lat2), 32'd1);
        rises = 0;
        lows  = 0;
        k     = 0;
        prev  = p_clk2;
        do begin
            @(negedge clk);
            k++;
            if (p_clk2 && !prev) rises++;
            if (!p_oe_n2) lows++;
            prev = p_clk2;
        end while (!p_lat2 && k < 100);
        chk("small row period", 32'(k), 32'd20);
        chk("small clk edges", 32'(rises), 32'd8);
        chk("small oe low", 32'(lows), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Panel-side scan driver sitting directly downstream of `matrix_generate`. Sweeps column/row indices into `matrix_generate`, captures the six colour bits it returns, and drives a HUB75 1/16-scan RGB panel: shift clock, latch, output enable, row address. Also emits a one-cycle end-of-frame tick that game logic uses as its time base.

## Interface
Parameters:
- `COLS`, 64, pixels shifted per row (power of two, ≥ 2)
- `ROWS_HALF`, 16, scan rows per half-panel; `addr` width is `$clog2(ROWS_HALF)`
- `ON_CYCLES`, 64, clocks the latched row is displayed (≥ 1)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `enable`  in  1  scanning allowed
- `col`  out  `$clog2(COLS)`  column index presented to `matrix_generate`
- `row`  out  `$clog2(ROWS_HALF)`  row index presented to `matrix_generate`
- `R0`,`G0`,`B0`,`R1`,`G1`,`B1`  in  1 each  pixel bits from `matrix_generate` for current `col`/`row`, combinational
- `p_r0`,`p_g0`,`p_b0`,`p_r1`,`p_g1`,`p_b1`  out  1 each  registered panel data
- `p_clk`  out  1  panel shift clock
- `p_lat`  out  1  panel latch
- `p_oe_n`  out  1  panel output enable, active-low
- `p_addr`  out  `$clog2(ROWS_HALF)`  panel row address
- `frame_tick`  out  1  one-cycle pulse at end of each full frame

## Operation
- All outputs registered. Reset values: `col`=0, `row`=0, `p_*` data 0, `p_clk`=0, `p_lat`=0, `p_oe_n`=1, `p_addr`=0, `frame_tick`=0, state IDLE, counters 0.
- States: IDLE → PREFETCH → SHIFT → BLANK → LATCH → DISPLAY → (PREFETCH or IDLE).
- IDLE: `p_oe_n`=1, `p_clk`=0. Leave to PREFETCH when `enable`=1.
- PREFETCH (1 cycle): `col`=0. At cycle end, load `p_*` data from `R0..B1`. Set `col`=1.
- SHIFT: 2 clocks per pixel.
  - L phase: `p_clk`=0, data for column c stable, `col`=c+1 (column wraps to 0 after COLS−1, don't-care).
  - H phase: `p_clk`=1. At end of H, load data for c+1 from `R0..B1`.
  - After the H phase of column COLS−1, go to BLANK. Exactly COLS rising edges of `p_clk` per row.
  - `p_oe_n`=1 throughout SHIFT (no overlap with display).
- BLANK (1 cycle): `p_oe_n`=1, `p_clk`=0, `p_addr`←`row`.
- LATCH (1 cycle): `p_lat`=1. `p_lat` is 0 in every other state.
- DISPLAY (ON_CYCLES cycles): `p_oe_n`=0; on-counter counts 0..ON_CYCLES−1.
  - On exit, `row` increments, wrapping ROWS_HALF−1→0.
  - On wrap, `frame_tick`=1 for exactly the first cycle after DISPLAY.
  - Exit to PREFETCH if `enable`=1, else IDLE.
- `enable` falling mid-row: current row completes through DISPLAY, then IDLE. `row` is retained, so the next enable resumes at the following row.
- `rst` mid-operation: every output takes its reset value on the next edge. No partial latch pulse survives reset.

## Timing
- Pixel lookup latency: `col`/`row` → `R0..B1` is combinational and must settle within one clock. The driver samples one full cycle after presenting a new `col`.
- `p_*` data changes only on the L-phase edge. Rising `p_clk` falls mid-data-window (1 clk setup, 1 clk hold).
- Row period = 1 + 2·COLS + 1 + 1 + ON_CYCLES. With defaults: 195 clocks. Frame = 3120 clocks.
- `frame_tick` spacing equals the frame period while `enable` is held high.

## Structure
- Shared package `hub75_pkg`:
  - state enum (`S_IDLE`, `S_PREFETCH`, `S_SHIFT`, `S_BLANK`, `S_LATCH`, `S_DISPLAY`)
  - default `COLS`/`ROWS_HALF`/`ON_CYCLES` constants
- Single module, no sub-module. Column, phase and on-time counters are inline.

## Test plan
- Reset then `enable`=1, upstream returns R0=`col[0]`: 64 `p_clk` rising edges per row; `p_r0` at the k-th edge = k mod 2; `p_lat` high exactly 1 cycle after BLANK.
- Row sweep with defaults: `p_addr` sequence 0,1,…,15,0. `frame_tick` pulses exactly every 3120 clocks, each pulse 1 cycle wide.
- `p_oe_n` low exactly 64 consecutive cycles per row, and never low while `p_clk` toggles or `p_lat`=1.
- Drop `enable` at SHIFT column 10 of row 3: row 3 completes, LATCH and DISPLAY occur, then IDLE with `p_oe_n`=1. Re-enable: first `p_addr` = 4.
- Assert `rst` for 1 cycle during DISPLAY of row 7: next cycle all outputs are at reset values. On re-enable, scanning restarts at row 0.
- Override `COLS`=8, `ON_CYCLES`=1: row period = 20 clocks, 8 `p_clk` edges per row.
